// File: rtl/morse_tx_param_pkg.sv
// Shared definitions for the Morse transmitter: FSM states, letter ROM, code range.
// The WGAP state exists only when MORSE_REPEAT_EN is defined.
package morse_tx_param_pkg;

  localparam logic [4:0] MAX_CODE = 5'd25;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MARK  = 3'd1,
    ST_SPACE = 3'd2,
`ifdef MORSE_REPEAT_EN
    ST_LGAP  = 3'd3,
    ST_WGAP  = 3'd4
`else
    ST_LGAP  = 3'd3
`endif
  } state_t;

  // len = element count (1..4); pat is MSB-first, 1 = dash, unused low bits 0
  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pat;
  } morse_sym_t;

  function automatic morse_sym_t morse_lut(input logic [4:0] code);
    morse_sym_t sym;
    case (code)
      5'd0:    sym = {3'd2, 4'b0100};  // A .-
      5'd1:    sym = {3'd4, 4'b1000};  // B -...
      5'd2:    sym = {3'd4, 4'b1010};  // C -.-.
      5'd3:    sym = {3'd3, 4'b1000};  // D -..
      5'd4:    sym = {3'd1, 4'b0000};  // E .
      5'd5:    sym = {3'd4, 4'b0010};  // F ..-.
      5'd6:    sym = {3'd3, 4'b1100};  // G --.
      5'd7:    sym = {3'd4, 4'b0000};  // H ....
      5'd8:    sym = {3'd2, 4'b0000};  // I ..
      5'd9:    sym = {3'd4, 4'b0111};  // J .---
      5'd10:   sym = {3'd3, 4'b1010};  // K -.-
      5'd11:   sym = {3'd4, 4'b0100};  // L .-..
      5'd12:   sym = {3'd2, 4'b1100};  // M --
      5'd13:   sym = {3'd2, 4'b1000};  // N -.
      5'd14:   sym = {3'd3, 4'b1110};  // O ---
      5'd15:   sym = {3'd4, 4'b0110};  // P .--.
      5'd16:   sym = {3'd4, 4'b1101};  // Q --.-
      5'd17:   sym = {3'd3, 4'b0100};  // R .-.
      5'd18:   sym = {3'd3, 4'b0000};  // S ...
      5'd19:   sym = {3'd1, 4'b1000};  // T -
      5'd20:   sym = {3'd3, 4'b0010};  // U ..-
      5'd21:   sym = {3'd4, 4'b0001};  // V ...-
      5'd22:   sym = {3'd3, 4'b0110};  // W .--
      5'd23:   sym = {3'd4, 4'b1001};  // X -..-
      5'd24:   sym = {3'd4, 4'b1011};  // Y -.--
      5'd25:   sym = {3'd4, 4'b1100};  // Z --..
      default: sym = {3'd1, 4'b0000};
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/morse_tx_param_unit_tick.sv
// Unit prescaler: counts 0..CLK_PER_UNIT-1 and flags the last cycle of each unit.
// clear holds the count at zero so a new phase always starts on a unit boundary.
module morse_unit_tick #(
  parameter int CLK_PER_UNIT = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic unit_tick
);

  localparam int CW = $clog2(CLK_PER_UNIT);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_UNIT - 1);

  logic [CW-1:0] cnt_r;

  // prescaler count, reloaded explicitly at the end of each unit
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign unit_tick = (cnt_r == LAST);

endmodule

// File: rtl/morse_tx_param.sv
// Parametrised Morse letter transmitter with start/busy/done/err handshake.
// Define MORSE_REPEAT_EN to add the rpt port and beacon (word-gap + replay) mode.
module morse_tx_param
  import morse_tx_param_pkg::*;
#(
  parameter int CLK_PER_UNIT   = 25_000_000,
  parameter int DASH_UNITS     = 3,
  parameter int SYM_GAP_UNITS  = 1,
  parameter int LTR_GAP_UNITS  = 3,
  parameter int WORD_GAP_UNITS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] code,
`ifdef MORSE_REPEAT_EN
  input  logic       rpt,
`endif
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t     state_r, state_s;
  morse_sym_t sym_r;
  logic [1:0] elem_r;
  logic [3:0] unit_r;
  logic [3:0] target_s;
  logic       tick_s, clear_s, phase_end_s, last_elem_s, cur_dash_s;
  logic       led_s, busy_s, done_s, err_s;

  assign clear_s     = (state_r == ST_IDLE);
  assign cur_dash_s  = sym_r.pat[2'd3 - elem_r];
  assign last_elem_s = ({1'b0, elem_r} == (sym_r.len - 3'd1));
  assign phase_end_s = tick_s && (unit_r == (target_s - 4'd1));

  morse_unit_tick #(.CLK_PER_UNIT(CLK_PER_UNIT)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .unit_tick (tick_s)
  );

  // length of the current phase in units
  always_comb begin
    target_s = 4'd1;
    case (state_r)
      ST_MARK:  target_s = cur_dash_s ? 4'(DASH_UNITS) : 4'd1;
      ST_SPACE: target_s = 4'(SYM_GAP_UNITS);
      ST_LGAP:  target_s = 4'(LTR_GAP_UNITS);
`ifdef MORSE_REPEAT_EN
      ST_WGAP:  target_s = 4'(WORD_GAP_UNITS - LTR_GAP_UNITS);
`endif
      default:  target_s = 4'd1;
    endcase
  end

  // state register and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      led     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_s;
      led     <= led_s;
      busy    <= busy_s;
      done    <= done_s;
      err     <= err_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (code <= MAX_CODE)) state_s = ST_MARK;
        else                             state_s = ST_IDLE;
      end
      ST_MARK: begin
        if (phase_end_s) state_s = last_elem_s ? ST_LGAP : ST_SPACE;
        else             state_s = ST_MARK;
      end
      ST_SPACE: begin
        if (phase_end_s) state_s = ST_MARK;
        else             state_s = ST_SPACE;
      end
      ST_LGAP: begin
`ifdef MORSE_REPEAT_EN
        if (phase_end_s) state_s = rpt ? ST_WGAP : ST_IDLE;
`else
        if (phase_end_s) state_s = ST_IDLE;
`endif
        else             state_s = ST_LGAP;
      end
`ifdef MORSE_REPEAT_EN
      ST_WGAP: begin
        if (phase_end_s) state_s = ST_MARK;
        else             state_s = ST_WGAP;
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // output decode, registered next cycle so outputs line up with the new state
  always_comb begin
    led_s  = (state_s == ST_MARK);
    busy_s = (state_s != ST_IDLE);
    done_s = (state_r == ST_LGAP) && phase_end_s;
    err_s  = (state_r == ST_IDLE) && start && (code > MAX_CODE);
  end

  // unit/element counters and latched letter
  always_ff @(posedge clk) begin
    if (!reset) begin
      sym_r  <= '0;
      elem_r <= 2'd0;
      unit_r <= 4'd0;
    end else if (state_r == ST_IDLE) begin
      elem_r <= 2'd0;
      unit_r <= 4'd0;
      if (start && (code <= MAX_CODE)) sym_r <= morse_lut(code);
      else                             sym_r <= sym_r;
    end else if (phase_end_s) begin
      unit_r <= 4'd0;
      sym_r  <= sym_r;
      if (state_r == ST_SPACE)     elem_r <= elem_r + 2'd1;
      else if (state_r == ST_LGAP) elem_r <= 2'd0;
      else                         elem_r <= elem_r;
    end else begin
      sym_r  <= sym_r;
      elem_r <= elem_r;
      if (tick_s) unit_r <= unit_r + 4'd1;
      else        unit_r <= unit_r;
    end
  end

endmodule

// File: tb/tb_morse_tx_param.sv
// Self-checking bench for morse_tx_param (CLK_PER_UNIT=4); covers MORSE_REPEAT_EN when defined.
module tb_morse_tx_param;

  localparam int CPU = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] code = 5'd0;
`ifdef MORSE_REPEAT_EN
  logic       rpt = 1'b0;
`endif
  logic       led, busy, done, err;

  always #5 clk = ~clk;

  morse_tx_param #(.CLK_PER_UNIT(CPU)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .code  (code),
`ifdef MORSE_REPEAT_EN
    .rpt   (rpt),
`endif
    .led   (led),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Reference model: Morse alphabet as dot/dash text, expanded into per-cycle {led,busy,done,err}
  string tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                      "..-", "...-", ".--", "-..-", "-.--", "--.."};
  logic [3:0] expq [$];
  logic [3:0] cur = 4'b0000;
  logic [3:0] model_e;
  int         model_code = 0;

  task automatic push_letter(input int c);
    string s = tbl[c];
    for (int i = 0; i < s.len(); i++) begin
      repeat (((s[i] == "-") ? 3 : 1) * CPU) expq.push_back(4'b1100);
      if (i != s.len() - 1) repeat (1 * CPU) expq.push_back(4'b0100);
    end
    repeat (3 * CPU) expq.push_back(4'b0100);
    expq.push_back(4'b0010);
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      expq.delete();
      cur <= 4'b0000;
    end else begin
      if (expq.size() == 0 && start) begin
        if (code <= 5'd25) begin
          model_code = int'(code);
          push_letter(model_code);
        end else begin
          expq.push_back(4'b0001);
        end
      end
      if (expq.size() > 0) model_e = expq.pop_front();
      else                 model_e = 4'b0000;
`ifdef MORSE_REPEAT_EN
      if (model_e == 4'b0010 && rpt) begin
        model_e = 4'b0110;
        repeat ((7 - 3) * CPU - 1) expq.push_back(4'b0100);
        push_letter(model_code);
      end
`endif
      cur <= model_e;
    end
  end

  always @(negedge clk) begin
    if ($time > 0) chk("cycle", int'({led, busy, done, err}), int'(cur));
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((expq.size() > 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", int'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  // one start (or held start), then count outputs over win cycles; j=0 is the cycle after the start edge
  task automatic measure(input int c, input int win, input bit hold,
                         output int led_n, output int busy_n, output int done_n,
                         output int done_at, output int err_n);
    led_n = 0; busy_n = 0; done_n = 0; done_at = -1; err_n = 0;
    @(negedge clk);
    start = 1'b1;
    code  = 5'(c);
    for (int j = 0; j < win; j++) begin
      @(negedge clk);
      if (j == 0 && !hold) start = 1'b0;
      led_n  += int'(led);
      busy_n += int'(busy);
      err_n  += int'(err);
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
    end
    start = 1'b0;
  endtask

  int ln, bn, dn, da, en;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_led", int'(led), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done_err", int'({done, err}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // E: 4 on, 12 off, done at 16
    measure(4, 24, 1'b0, ln, bn, dn, da, en);
    chk("E_led", ln, 4);   chk("E_busy", bn, 16);
    chk("E_done", dn, 1);  chk("E_done_at", da, 16);
    wait_idle(50);

    // A: 4 on, 4 off, 12 on, 12 off
    measure(0, 40, 1'b0, ln, bn, dn, da, en);
    chk("A_led", ln, 16);  chk("A_busy", bn, 32);
    chk("A_done", dn, 1);  chk("A_done_at", da, 32);
    wait_idle(50);

    // bad code then Q
    measure(27, 4, 1'b0, ln, bn, dn, da, en);
    chk("err_pulse", en, 1); chk("err_busy", bn, 0); chk("err_led", ln, 0);
    measure(16, 70, 1'b0, ln, bn, dn, da, en);
    chk("Q_led", ln, 40);  chk("Q_busy", bn, 64);  chk("Q_done_at", da, 64);
    wait_idle(50);

    // T with a mid-letter start for E and a code change while busy
    @(negedge clk); start = 1'b1; code = 5'd19;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; code = 5'd4;
    @(negedge clk); start = 1'b0; code = 5'd30;
    wait_idle(100);
    chk("T_ignore_busy", int'(busy), 0);

    // reset in the middle of T's dash, then a full T
    @(negedge clk); start = 1'b1; code = 5'd19;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_led", int'(led), 0);
    chk("rst_mid_busy", int'(busy), 0);
    reset = 1'b1;
    @(negedge clk);
    measure(19, 30, 1'b0, ln, bn, dn, da, en);
    chk("T_led", ln, 12);  chk("T_busy", bn, 24);  chk("T_done_at", da, 24);
    wait_idle(50);

    // start held high: second E accepted right after the done cycle
    measure(4, 34, 1'b1, ln, bn, dn, da, en);
    chk("b2b_done", dn, 2); chk("b2b_led", ln, 8);
    wait_idle(50);

`ifdef MORSE_REPEAT_EN
    // beacon: marks at j=0..3 and 32..35, done at 16 and 48
    rpt = 1'b1;
    measure(4, 60, 1'b0, ln, bn, dn, da, en);
    chk("rpt_done", dn, 2);  chk("rpt_led", ln, 8);
    chk("rpt_busy", bn, 60); chk("rpt_done_at", da, 16);
    rpt = 1'b0;
    wait_idle(100);
    chk("rpt_stop_busy", int'(busy), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
